// File: rtl/nvdla_glb_intr_pkg.sv
// Shared constants and types for the global CSB register / interrupt block:
// CSB packet layouts, register offsets and small decode helpers.
package nvdla_glb_intr_pkg;

    localparam int CSB_REQ_W  = 63;
    localparam int CSB_RESP_W = 34;

    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_ADDR_W      = 22;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_LEVEL_LSB   = 61;

    localparam int RESP_WRITE_BIT = 33;
    localparam int RESP_ERR_BIT   = 32;

    localparam logic [11:0] GLB_OFS_HWVER  = 12'h000;
    localparam logic [11:0] GLB_OFS_MASK   = 12'h004;
    localparam logic [11:0] GLB_OFS_SET    = 12'h008;
    localparam logic [11:0] GLB_OFS_STATUS = 12'h00C;

    typedef enum logic [2:0] {
        REG_HWVER,
        REG_MASK,
        REG_SET,
        REG_STATUS,
        REG_NONE
    } glb_reg_e;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] wdat;
        logic        write;
        logic        nposted;
        logic [3:0]  wrbe;
    } glb_req_t;

    // Only the low 10 word-address bits select a register.
    function automatic glb_reg_e decode_ofs(input logic [9:0] addr);
        logic [11:0] ofs;
        ofs = {addr, 2'b00};
        case (ofs)
            GLB_OFS_HWVER:  decode_ofs = REG_HWVER;
            GLB_OFS_MASK:   decode_ofs = REG_MASK;
            GLB_OFS_SET:    decode_ofs = REG_SET;
            GLB_OFS_STATUS: decode_ofs = REG_STATUS;
            default:        decode_ofs = REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] be_expand(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/nvdla_glb_intr_if.sv
// CSB request/response bundle between the CSB master and the global block.
interface nvdla_glb_intr_if;
    import nvdla_glb_intr_pkg::*;

    logic                  csb2glb_req_pvld;
    logic                  csb2glb_req_prdy;
    logic [CSB_REQ_W-1:0]  csb2glb_req_pd;
    logic                  glb2csb_resp_valid;
    logic [CSB_RESP_W-1:0] glb2csb_resp_pd;

    modport master (
        output csb2glb_req_pvld,
        output csb2glb_req_pd,
        input  csb2glb_req_prdy,
        input  glb2csb_resp_valid,
        input  glb2csb_resp_pd
    );

    modport slave (
        input  csb2glb_req_pvld,
        input  csb2glb_req_pd,
        output csb2glb_req_prdy,
        output glb2csb_resp_valid,
        output glb2csb_resp_pd
    );

endinterface

// File: rtl/nvdla_glb_intr_reg.sv
// Register file of the global block: decode, byte-enable merge, mask and
// sticky W1C status storage, read mux and the aggregated interrupt.
module nvdla_glb_intr_reg
    import nvdla_glb_intr_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 16,
    parameter logic [31:0]       HW_VERSION = 32'h00003130,
    parameter logic [NUM_CH-1:0] MASK_RST   = {NUM_CH{1'b1}}
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              req_vld,
    input  logic              req_write,
    input  logic [9:0]        req_addr,
    input  logic [31:0]       req_wdat,
    input  logic [3:0]        req_wrbe,
    input  logic [NUM_CH-1:0] done_pulse,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic [NUM_CH-1:0] done_mask,
    output logic              glb_intr
);

    glb_reg_e          sel;
    logic              wr_en;
    logic [31:0]       be_bits;
    logic [31:0]       wdat_be;
    logic [NUM_CH-1:0] ch_be;
    logic [NUM_CH-1:0] ch_wdat;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_n;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] status_n;
    logic [NUM_CH-1:0] w1s;
    logic [NUM_CH-1:0] w1c;

    always_comb begin
        sel     = decode_ofs(req_addr);
        be_bits = be_expand(req_wrbe);
        wdat_be = req_wdat & be_bits;
    end

    assign wr_en   = req_vld & req_write;
    assign ch_be   = be_bits[NUM_CH-1:0];
    assign ch_wdat = wdat_be[NUM_CH-1:0];

    // Register bits above the channel count do not exist; writes to them drop.
    if (NUM_CH < 32) begin : g_hi
        logic unused_hi_bits;
        assign unused_hi_bits = ^{be_bits[31:NUM_CH], wdat_be[31:NUM_CH]};
    end

    always_comb begin
        mask_n = mask;
        w1s    = '0;
        w1c    = '0;
        if (wr_en) begin
            case (sel)
                REG_MASK:   mask_n = (mask & ~ch_be) | ch_wdat;
                REG_SET:    w1s    = ch_wdat;
                REG_STATUS: w1c    = ch_wdat;
                default:    ;
            endcase
        end
        // Sets take priority over a same-cycle clear.
        status_n = (status & ~w1c) | done_pulse | w1s;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mask     <= MASK_RST;
            status   <= '0;
            glb_intr <= 1'b0;
        end else begin
            mask     <= mask_n;
            status   <= status_n;
            glb_intr <= |(status & ~mask);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (sel)
            REG_HWVER:  rd_data = HW_VERSION;
            REG_MASK:   rd_data[NUM_CH-1:0] = mask;
            REG_SET:    ;
            REG_STATUS: rd_data[NUM_CH-1:0] = status;
            default:    rd_err = 1'b1;
        endcase
    end

    assign done_mask = mask;

endmodule

// File: rtl/nvdla_glb_intr_csb.sv
// Global CSB register/interrupt block: two-stage CSB request/response
// pipeline wrapped around the register file.
module nvdla_glb_intr_csb
    import nvdla_glb_intr_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 16,
    parameter logic [31:0]       HW_VERSION = 32'h00003130,
    parameter logic [NUM_CH-1:0] MASK_RST   = {NUM_CH{1'b1}}
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    nvdla_glb_intr_if.slave   csb,
    input  logic [NUM_CH-1:0] done_pulse,
    output logic [NUM_CH-1:0] done_mask,
    output logic              glb_intr
);

    glb_req_t        req_in;
    glb_req_t        req_p1;
    logic            req_vld_p1;
    logic [31:0]     rd_data;
    logic            rd_err;
    logic            resp_go;
    logic            resp_valid_p2;
    logic [CSB_RESP_W-1:0] resp_pd_p2;
    logic            unused_req_bits;

    always_comb begin
        req_in.addr    = csb.csb2glb_req_pd[REQ_ADDR_LSB +: 10];
        req_in.wdat    = csb.csb2glb_req_pd[REQ_WDAT_LSB +: 32];
        req_in.write   = csb.csb2glb_req_pd[REQ_WRITE_BIT];
        req_in.nposted = csb.csb2glb_req_pd[REQ_NPOSTED_BIT];
        req_in.wrbe    = csb.csb2glb_req_pd[REQ_WRBE_LSB +: 4];
    end

    assign unused_req_bits = ^{csb.csb2glb_req_pd[REQ_LEVEL_LSB +: 2],
                               csb.csb2glb_req_pd[REQ_SRCPRIV_BIT],
                               csb.csb2glb_req_pd[REQ_ADDR_LSB + 10 +: REQ_ADDR_W - 10]};

    assign csb.csb2glb_req_prdy = 1'b1;

    // Stage p1: capture the request.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_vld_p1 <= 1'b0;
        end else begin
            req_vld_p1 <= csb.csb2glb_req_pvld;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (csb.csb2glb_req_pvld) begin
            req_p1 <= req_in;
        end
    end

    nvdla_glb_intr_reg #(
        .NUM_CH     (NUM_CH),
        .HW_VERSION (HW_VERSION),
        .MASK_RST   (MASK_RST)
    ) u_reg (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .req_vld         (req_vld_p1),
        .req_write       (req_p1.write),
        .req_addr        (req_p1.addr),
        .req_wdat        (req_p1.wdat),
        .req_wrbe        (req_p1.wrbe),
        .done_pulse      (done_pulse),
        .rd_data         (rd_data),
        .rd_err          (rd_err),
        .done_mask       (done_mask),
        .glb_intr        (glb_intr)
    );

    assign resp_go = req_vld_p1 & (~req_p1.write | req_p1.nposted);

    // Stage p2: register the response; posted writes leave the last one held.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            resp_valid_p2 <= 1'b0;
            resp_pd_p2    <= '0;
        end else begin
            resp_valid_p2 <= resp_go;
            if (resp_go) begin
                resp_pd_p2 <= {req_p1.write, rd_err, (req_p1.write ? 32'h0 : rd_data)};
            end
        end
    end

    assign csb.glb2csb_resp_valid = resp_valid_p2;
    assign csb.glb2csb_resp_pd    = resp_pd_p2;

endmodule

// File: tb/tb_nvdla_glb_intr_csb.sv
// Scoreboard bench for nvdla_glb_intr_csb: directed CSB traffic with
// hand-computed responses, checked by an independent response monitor.
module tb_nvdla_glb_intr_csb;
    import nvdla_glb_intr_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] done_pulse = '0;
    logic [15:0] done_mask;
    logic        glb_intr;

    nvdla_glb_intr_if csb_if();

    nvdla_glb_intr_csb #(.NUM_CH(16)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .csb             (csb_if),
        .done_pulse      (done_pulse),
        .done_mask       (done_mask),
        .glb_intr        (glb_intr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [33:0] pd;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response cycle must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (csb_if.glb2csb_resp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected: got pd %h, expected no response", csb_if.glb2csb_resp_pd);
            end else begin
                mon_e = sb.pop_front();
                check("resp_pd", csb_if.glb2csb_resp_pd, mon_e.pd);
                check("resp_cycle", 34'(cyc), 34'(mon_e.at));
            end
        end
    end

    task automatic put(input logic v, input logic [11:0] ofs, input logic [31:0] wd,
                       input logic wr, input logic np, input logic [3:0] be,
                       input logic [15:0] pulse);
        logic [62:0] pd;
        @(posedge clk);
        #1;
        pd = '0;
        pd[REQ_ADDR_LSB +: 22]  = {12'h0, ofs[11:2]};
        pd[REQ_WDAT_LSB +: 32]  = wd;
        pd[REQ_WRITE_BIT]       = wr;
        pd[REQ_NPOSTED_BIT]     = np;
        pd[REQ_WRBE_LSB +: 4]   = be;
        pd[REQ_LEVEL_LSB +: 2]  = 2'b01;
        csb_if.csb2glb_req_pvld = v;
        csb_if.csb2glb_req_pd   = pd;
        done_pulse              = pulse;
    endtask

    task automatic rd(input logic [11:0] ofs, input logic [31:0] data, input logic err,
                      input logic [15:0] pulse = '0);
        put(1'b1, ofs, 32'h0, 1'b0, 1'b0, 4'h0, pulse);
        sb.push_back('{pd: {1'b0, err, data}, at: cyc + 2});
    endtask

    task automatic wr(input logic [11:0] ofs, input logic [31:0] wd, input logic [3:0] be,
                      input logic np, input logic err, input logic [15:0] pulse = '0);
        put(1'b1, ofs, wd, 1'b1, np, be, pulse);
        if (np) sb.push_back('{pd: {1'b1, err, 32'h0}, at: cyc + 2});
    endtask

    task automatic idle(input logic [15:0] pulse = '0);
        put(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 4'h0, pulse);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        csb_if.csb2glb_req_pvld = 1'b0;
        csb_if.csb2glb_req_pd   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", csb_if.glb2csb_resp_valid, 1'b0);
        check("rst_resp_pd", csb_if.glb2csb_resp_pd, 34'h0);
        check("rst_mask", done_mask, 16'hFFFF);
        check("rst_intr", glb_intr, 1'b0);
        check("prdy", csb_if.csb2glb_req_prdy, 1'b1);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Version read and reset mask
        rd(12'h000, 32'h0000_3130, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("mask_after_rst", done_mask, 16'hFFFF);
        check("intr_idle", glb_intr, 1'b0);

        // Unmask channel 0 with partial byte enables, then pulse it
        wr(12'h004, 32'h0000_FFFE, 4'b0011, 1'b1, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("mask_fffe", done_mask, 16'hFFFE);
        idle(16'h0001);
        @(negedge clk);
        check("intr_pulse_p0", glb_intr, 1'b0);
        idle();
        @(negedge clk);
        check("intr_pulse_p1", glb_intr, 1'b0);
        idle();
        @(negedge clk);
        check("intr_pulse_p2", glb_intr, 1'b1);

        // W1C colliding with a pulse: set wins
        wr(12'h00C, 32'h1, 4'b1111, 1'b1, 1'b0);
        idle(16'h0001);
        rd(12'h00C, 32'h1, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("intr_set_wins", glb_intr, 1'b1);

        // Plain W1C: status clears, interrupt falls one cycle later
        wr(12'h00C, 32'h1, 4'b1111, 1'b1, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("intr_clr_lag", glb_intr, 1'b1);
        idle();
        @(negedge clk);
        check("intr_cleared", glb_intr, 1'b0);
        rd(12'h00C, 32'h0, 1'b0);

        // Posted SET followed immediately by a STATUS read
        wr(12'h004, 32'h0, 4'b1111, 1'b1, 1'b0);
        wr(12'h008, 32'h0000_8000, 4'b1111, 1'b0, 1'b0);
        rd(12'h00C, 32'h0000_8000, 1'b0);
        rd(12'h008, 32'h0, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("intr_set_reg", glb_intr, 1'b1);
        check("mask_zero", done_mask, 16'h0000);

        // Byte enables, wrbe=0 no-op, dropped high bits
        wr(12'h008, 32'h0000_0F0F, 4'b0010, 1'b0, 1'b0);
        rd(12'h00C, 32'h0000_8F00, 1'b0);
        wr(12'h00C, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0);
        rd(12'h00C, 32'h0000_8F00, 1'b0);
        wr(12'h004, 32'hABCD_1234, 4'b1111, 1'b1, 1'b0);
        rd(12'h004, 32'h0000_1234, 1'b0);
        wr(12'h004, 32'h0000_5600, 4'b0010, 1'b1, 1'b0);
        rd(12'h004, 32'h0000_5634, 1'b0);

        // Unmapped offset and read-only version register
        rd(12'h010, 32'h0, 1'b1);
        wr(12'h010, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b1);
        wr(12'h000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0);
        rd(12'h004, 32'h0000_5634, 1'b0);
        rd(12'h00C, 32'h0000_8F00, 1'b0);
        rd(12'h000, 32'h0000_3130, 1'b0);
        idle(); idle();
        @(negedge clk);
        check("intr_masked_mix", glb_intr, 1'b1);

        // Back-to-back reads
        rd(12'h000, 32'h0000_3130, 1'b0);
        rd(12'h004, 32'h0000_5634, 1'b0);
        rd(12'h008, 32'h0, 1'b0);
        rd(12'h00C, 32'h0000_8F00, 1'b0);
        rd(12'h010, 32'h0, 1'b1);
        idle(); idle(); idle();

        // Reset in the middle of a read burst
        rd(12'h000, 32'h0000_3130, 1'b0);
        put(1'b1, 12'h000, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        put(1'b1, 12'h000, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        #5 rstn = 1'b0;
        put(1'b1, 12'h000, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        put(1'b1, 12'h000, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        idle();
        @(negedge clk);
        check("mid_rst_valid", csb_if.glb2csb_resp_valid, 1'b0);
        check("mid_rst_pd", csb_if.glb2csb_resp_pd, 34'h0);
        check("mid_rst_intr", glb_intr, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(); idle(); idle(); idle();
        rd(12'h00C, 32'h0, 1'b0);
        rd(12'h004, 32'h0000_FFFF, 1'b0);
        idle(); idle(); idle();
        @(negedge clk);
        check("post_rst_intr", glb_intr, 1'b0);
        check("post_rst_mask", done_mask, 16'hFFFF);
        check("sb_drained", 34'(sb.size()), 34'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nvdla_glb_intr_csb.md
Name: nvdla_glb_intr_csb

Overview:
- Parametrised successor of the global CSB register/interrupt block.
- Accepts CSB requests and returns read/non-posted-write responses with fixed 2-cycle latency.
- Owns sticky per-channel done-status bits, a mask register and a software set register for NUM_CH sub-unit done sources.
- Drives one aggregated level interrupt to the core wrapper.
- New versus the previous generation: channel count is a parameter; status is latched and write-1-to-clear; byte enables are honoured; unmapped offsets return an error response.

Parameters:
- NUM_CH, 16, number of done sources (1..32); bit i of every register is channel i.
- HW_VERSION, 32'h00003130, value returned at offset 0x000.
- MASK_RST, {NUM_CH{1'b1}}, reset value of the mask (all sources masked).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- csb2glb_req_pvld  in  1  request valid
- csb2glb_req_prdy  out  1  request ready; tied 1
- csb2glb_req_pd  in  63  request: [21:0] addr (word), [53:22] wdat, [54] write, [55] nposted, [56] srcpriv (unused), [60:57] wrbe, [62:61] level (unused)
- glb2csb_resp_valid  out  1  response valid (no backpressure)
- glb2csb_resp_pd  out  34  response: [33] 0=read/1=write, [32] error, [31:0] rdata (0 for writes)
- done_pulse  in  NUM_CH  one-cycle done pulse per channel
- done_mask  out  NUM_CH  current mask register
- glb_intr  out  1  registered OR of (status & ~mask)

Behaviour:
- Reset values: resp_valid 0; resp_pd 0; status 0; mask MASK_RST; glb_intr 0.
- Request stage: the request is captured every cycle pvld=1 (req_vld <= pvld; req_pd loaded on pvld).
- Request decode: offset = {addr[9:0],2'b00}.
- Register map:
  - 0x000 HW_VERSION: RO; write ignored, no error.
  - 0x004 INTR_MASK: RW.
  - 0x008 INTR_SET: WO; reads return 0; write-1 sets status bits.
  - 0x00C INTR_STATUS: RO; write-1 clears bits.
  - Any other offset: read returns data 0 with error=1; write has no effect, and a non-posted write responds with error=1.
- Byte enables: wrbe[k] gates data bits [8k+7:8k] for MASK/SET/STATUS writes. wrbe=0 is a legal no-op write and still responds if non-posted.
- Bits at or above NUM_CH: read as 0, writes dropped.
- Latency:
  - pvld at cycle T -> req_vld at T+1 -> register write commits at the clock edge ending T+1 -> resp_valid at T+2 for exactly 1 cycle.
  - Back-to-back requests every cycle are supported and give back-to-back responses.
- Response generation:
  - Read: resp_valid always.
  - Write: resp_valid only if nposted=1.
  - Posted write: no response, resp_pd holds its old value.
- Read data: sampled in cycle T+1 from current register state, so a read issued the cycle after a write observes the written value.
- Status next-state per bit: status_n = (status & ~w1c) | done_pulse | w1s.
  - Set wins: a pulse or W1S in the same cycle as a W1C on the same bit leaves the bit at 1.
  - A pulse while the bit is already set is absorbed; there is no counter.
- Mask write takes effect the next cycle. glb_intr = registered |(status & ~mask), so it updates one cycle after status or mask changes.
- Reset asserted mid-transaction: the in-flight request is dropped and no response is issued after release; all state returns to reset values.
- No state machine beyond the 2-stage pipeline; prdy is never deasserted.

Decomposition:
- Package nvdla_glb_intr_pkg holds:
  - offset constants GLB_OFS_HWVER/MASK/SET/STATUS;
  - request/response field bit positions;
  - the widths 63 and 34.
- One sub-module nvdla_glb_intr_reg: decode, byte-enable merge, mask/status storage, read mux, error flag, glb_intr.
- The top holds the CSB request/response pipeline.

Test Plan:
- Reset, then read 0x000 -> resp at T+2 with pd = {1'b0,1'b0,32'h00003130}; done_mask=16'hFFFF; glb_intr=0.
- Non-posted write 0x004=32'h0000_FFFE with wrbe=4'b0011; pulse done_pulse[0] -> write resp {1,0,0}; status[0]=1; glb_intr=1 two cycles after the pulse.
- Write 0x00C=1 in the same cycle done_pulse[0]=1 -> status[0] stays 1. Write 0x00C=1 again with no pulse -> status[0]=0, glb_intr falls 1 cycle later.
- Posted write 0x008=32'h0000_8000 with wrbe=4'b1111, mask=0 -> no response; a read of 0x00C the next cycle returns 32'h0000_8000.
- Read 0x010 -> resp {0,1,32'h0}. Non-posted write 0x010 -> resp {1,1,0}; no register changes.
- Reads on 5 consecutive cycles -> 5 consecutive response cycles in order. Assert rstn low at the middle one -> no response after release, status=0.
